// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: 640x480@60 Hz timing constants, derived
// totals, sync window bounds and small decode helpers. Imported by the timing
// generator, the draw_* sprite blocks and the pixel mixer so they all agree on
// the same geometry.
package vga_pkg;

  // Raster counters are 10 bits wide, so every total must fit in 1024
  localparam int VGA_CNT_W = 10;

  typedef logic [VGA_CNT_W-1:0] coord_t;

  // A raster position, used when the horizontal and vertical counters travel together
  typedef struct packed {
    coord_t h;
    coord_t v;
  } raster_t;

  // System clocks per pixel: 100 MHz / 4 = 25 MHz pixel rate
  localparam int VGA_CLK_DIV = 4;

  // Horizontal timing, in pixels
  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;

  // Vertical timing, in lines
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // Sync pulses are active-low on the standard 640x480 mode
  localparam logic VGA_SYNC_POL = 1'b0;

  // Derived totals: 800 pixels per line, 525 lines per frame
  localparam int VGA_H_TOT = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOT = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows as half-open intervals [start, end): h 656..751, v 490..491
  localparam int VGA_HS_START = VGA_H_VIS + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_VIS + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC;

  // Drawable playfield: draw blocks use h_cnt>>1 / v_cnt>>1 as coordinates
  localparam int VGA_FIELD_W = VGA_H_VIS / 2;
  localparam int VGA_FIELD_H = VGA_V_VIS / 2;

  // Width of a counter that must hold values 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Unsigned half-open window test: lo <= pos < hi
  function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  // Convert an "inside sync window" flag into the pin level for a given polarity
  function automatic logic sync_drive(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: produces a one-clock pulse every DIV system clocks.
// Used as the VGA pixel-rate enable and reusable for game-tick timers. The
// first pulse appears DIV clocks after reset release.
module clk_en_div
  import vga_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic en_out
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // A divide ratio below two would make the enable permanently high or undefined
  if (DIV < 2) begin : g_chk_div
    $error("clk_en_div: DIV must be >= 2");
  end

  logic [CW-1:0] cnt;

  // Free-running 0..DIV-1 counter; the enable is registered off the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      en_out <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      en_out <= (cnt == CNT_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Divides the system clock down to the pixel
// rate, runs the horizontal/vertical position counters and decodes sync,
// active-video and line/frame strobes. Every decoded output is registered from
// the next-state counter values, so it changes on exactly the same edge as
// h_cnt/v_cnt and never lags them.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = VGA_CLK_DIV,
  parameter int   H_VIS    = VGA_H_VIS,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_VIS    = VGA_V_VIS,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pclk_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST  = 10'(H_TOT - 1);
  localparam coord_t V_LAST  = 10'(V_TOT - 1);
  localparam coord_t H_VIS_C = 10'(H_VIS);
  localparam coord_t V_VIS_C = 10'(V_VIS);
  localparam coord_t HS_LO   = 10'(H_VIS + H_FP);
  localparam coord_t HS_HI   = 10'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_LO   = 10'(V_VIS + V_FP);
  localparam coord_t VS_HI   = 10'(V_VIS + V_FP + V_SYNC);

  // The counters are 10 bits, so the raster must fit in 1024 x 1024
  if ((H_TOT > 1024) || (V_TOT > 1024)) begin : g_chk_size
    $error("vga_timing_gen: H_TOT and V_TOT must be <= 1024");
  end

  raster_t pos_nxt;
  logic    h_at_last;

  // Pixel-rate enable; h_cnt/v_cnt advance on the edge that follows each pulse
  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_pix_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_out (pclk_en)
  );

  // Next raster position: advance one pixel per enable, wrapping line then frame
  always_comb begin
    pos_nxt.h = h_cnt;
    pos_nxt.v = v_cnt;
    if (pclk_en) begin
      if (h_cnt == H_LAST) begin
        pos_nxt.h = '0;
        if (v_cnt == V_LAST) begin
          pos_nxt.v = '0;
        end else begin
          pos_nxt.v = v_cnt + 1'b1;
        end
      end else begin
        pos_nxt.h = h_cnt + 1'b1;
      end
    end
  end

  // Counter and decode registers, all loaded from the next position on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      valid       <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      h_at_last   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= pos_nxt.h;
      v_cnt       <= pos_nxt.v;
      valid       <= (pos_nxt.h < H_VIS_C) && (pos_nxt.v < V_VIS_C);
      hsync       <= sync_drive(in_window(pos_nxt.h, HS_LO, HS_HI), SYNC_POL);
      vsync       <= sync_drive(in_window(pos_nxt.v, VS_LO, VS_HI), SYNC_POL);
      h_at_last   <= (pos_nxt.h == H_LAST);
      frame_start <= pclk_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end
  end

  // line_end must coincide with the enable pulse itself, so it gates two flop outputs;
  // both fall together when the line wraps, so the product is clean.
  assign line_end = pclk_en & h_at_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Two instances share clock and reset: one with
// the default 640x480 geometry and one with a shrunken raster so that whole
// frames fit in a short run. A closed-form model derives the expected raster
// state from the number of clocks since reset release.
module tb_vga_timing_gen;

  localparam int S_DIV   = 4;
  localparam int S_HVIS  = 40;
  localparam int S_HFP   = 4;
  localparam int S_HSYNC = 8;
  localparam int S_HBP   = 8;
  localparam int S_VVIS  = 6;
  localparam int S_VFP   = 2;
  localparam int S_VSYNC = 2;
  localparam int S_VBP   = 2;
  localparam int S_HTOT  = S_HVIS + S_HFP + S_HSYNC + S_HBP;
  localparam int S_VTOT  = S_VVIS + S_VFP + S_VSYNC + S_VBP;
  localparam int S_FRAME = S_DIV * S_HTOT * S_VTOT;
  localparam int MAX_FAIL = 40;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       pclk;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fs;
  } snap_t;

  typedef struct {
    int div;
    int hvis, hfp, hsync, hbp;
    int vvis, vfp, vsync, vbp;
  } geom_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       d_pclk, d_valid, d_hs, d_vs, d_le, d_fs;
  logic [9:0] d_h, d_v;
  logic       s_pclk, s_valid, s_hs, s_vs, s_le, s_fs;
  logic [9:0] s_h, s_v;

  int    tests_run = 0;
  int    failed = 0;
  int    k = 0;
  geom_t g_d, g_s;
  snap_t rst_vals;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk         (clk),
    .rst_n       (rst_n),
    .pclk_en     (d_pclk),
    .h_cnt       (d_h),
    .v_cnt       (d_v),
    .valid       (d_valid),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .line_end    (d_le),
    .frame_start (d_fs)
  );

  vga_timing_gen #(
    .CLK_DIV (S_DIV),
    .H_VIS   (S_HVIS),
    .H_FP    (S_HFP),
    .H_SYNC  (S_HSYNC),
    .H_BP    (S_HBP),
    .V_VIS   (S_VVIS),
    .V_FP    (S_VFP),
    .V_SYNC  (S_VSYNC),
    .V_BP    (S_VBP)
  ) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .pclk_en     (s_pclk),
    .h_cnt       (s_h),
    .v_cnt       (s_v),
    .valid       (s_valid),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .line_end    (s_le),
    .frame_start (s_fs)
  );

  // Expected outputs k clocks after reset release (k = 0: before the first edge).
  // Pixel ticks arrive every div clocks starting at clock div; each is consumed
  // on the following edge, so p = floor((k-1)/div) pixels have elapsed.
  function automatic snap_t model(input int kk, input geom_t g);
    snap_t m;
    int htot, vtot, p, h, v;
    bit pclk, fs;
    htot = g.hvis + g.hfp + g.hsync + g.hbp;
    vtot = g.vvis + g.vfp + g.vsync + g.vbp;
    if (kk == 0) begin
      p = 0; pclk = 0; fs = 0;
    end else begin
      p    = (kk - 1) / g.div;
      pclk = (kk % g.div) == 0;
      fs   = (p > 0) && (((kk - 1) % g.div) == 0);
    end
    h = p % htot;
    v = (p / htot) % vtot;
    m.h     = 10'(h);
    m.v     = 10'(v);
    m.pclk  = pclk;
    m.valid = (h < g.hvis) && (v < g.vvis);
    m.hs    = !((h >= g.hvis + g.hfp) && (h < g.hvis + g.hfp + g.hsync));
    m.vs    = !((v >= g.vvis + g.vfp) && (v < g.vvis + g.vfp + g.vsync));
    m.le    = pclk && (h == htot - 1);
    m.fs    = fs && (h == 0) && (v == 0);
    return m;
  endfunction

  function automatic snap_t obs_d();
    snap_t o;
    o.h = d_h; o.v = d_v; o.pclk = d_pclk; o.valid = d_valid;
    o.hs = d_hs; o.vs = d_vs; o.le = d_le; o.fs = d_fs;
    return o;
  endfunction

  function automatic snap_t obs_s();
    snap_t o;
    o.h = s_h; o.v = s_v; o.pclk = s_pclk; o.valid = s_valid;
    o.hs = s_hs; o.vs = s_vs; o.le = s_le; o.fs = s_fs;
    return o;
  endfunction

  // Advance one clock and sample on the falling edge
  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int hold;
    hold = $urandom_range(5, 9);
    rst_n = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      tests_run++;
      if (obs_d() !== rst_vals) begin
        failed++;
        $display("[TB] FAIL reset_hold_def got %p want %p", obs_d(), rst_vals);
      end
      tests_run++;
      if (obs_s() !== rst_vals) begin
        failed++;
        $display("[TB] FAIL reset_hold_small got %p want %p", obs_s(), rst_vals);
      end
    end
    rst_n = 1'b1;
    k = 0;
    tests_run++;
    if (obs_d() !== rst_vals) begin
      failed++;
      $display("[TB] FAIL reset_release got %p want %p", obs_d(), rst_vals);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (obs_d() !== model(k, g_d)) begin
        failed++;
        $display("[TB] FAIL reset_start_def k=%0d got %p want %p", k, obs_d(), model(k, g_d));
      end
      tests_run++;
      if (obs_s() !== model(k, g_s)) begin
        failed++;
        $display("[TB] FAIL reset_start_small k=%0d got %p want %p", k, obs_s(), model(k, g_s));
      end
      if (k == 4) begin
        tests_run++;
        if (d_pclk !== 1'b1) begin
          failed++;
          $display("[TB] FAIL first_pclk_en got %b want 1", d_pclk);
        end
      end
      if (k == 5) begin
        tests_run++;
        if ((d_h !== 10'd1) || (d_v !== 10'd0)) begin
          failed++;
          $display("[TB] FAIL first_pixel got h=%0d v=%0d want h=1 v=0", d_h, d_v);
        end
      end
    end
  endtask

  task automatic test_pclk_spacing();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 40 && failed < MAX_FAIL; i++) begin
      tick();
      if (d_pclk === 1'b1) pulses++;
      tests_run++;
      if (obs_d() !== model(k, g_d)) begin
        failed++;
        $display("[TB] FAIL pclk_spacing k=%0d got %p want %p", k, obs_d(), model(k, g_d));
      end
    end
    tests_run++;
    if (pulses !== 10) begin
      failed++;
      $display("[TB] FAIL pclk_count got %0d want 10", pulses);
    end
  endtask

  task automatic test_hsync_line();
    int   hs_clks, le_pulses, valid_falls;
    logic prev_valid;
    hs_clks = 0; le_pulses = 0; valid_falls = 0;
    prev_valid = d_valid;
    for (int i = 0; i < 3200 && failed < MAX_FAIL; i++) begin
      tick();
      if (d_hs === 1'b0) hs_clks++;
      if (d_le === 1'b1) begin
        le_pulses++;
        tests_run++;
        if (d_h !== 10'd799) begin
          failed++;
          $display("[TB] FAIL line_end_pos got h=%0d want 799", d_h);
        end
      end
      if ((prev_valid === 1'b1) && (d_valid === 1'b0)) begin
        valid_falls++;
        tests_run++;
        if (d_h !== 10'd640) begin
          failed++;
          $display("[TB] FAIL valid_fall_pos got h=%0d want 640", d_h);
        end
      end
      prev_valid = d_valid;
      tests_run++;
      if (obs_d() !== model(k, g_d)) begin
        failed++;
        $display("[TB] FAIL hsync_line_def k=%0d got %p want %p", k, obs_d(), model(k, g_d));
      end
      tests_run++;
      if (obs_s() !== model(k, g_s)) begin
        failed++;
        $display("[TB] FAIL hsync_line_small k=%0d got %p want %p", k, obs_s(), model(k, g_s));
      end
    end
    tests_run++;
    if (hs_clks !== 384) begin
      failed++;
      $display("[TB] FAIL hsync_width got %0d clks want 384", hs_clks);
    end
    tests_run++;
    if (le_pulses !== 1) begin
      failed++;
      $display("[TB] FAIL line_end_count got %0d want 1", le_pulses);
    end
    tests_run++;
    if (valid_falls !== 1) begin
      failed++;
      $display("[TB] FAIL valid_fall_count got %0d want 1", valid_falls);
    end
  endtask

  task automatic test_vsync_frame();
    int   last_fs, vs_clks, periods;
    bit   wrap_next;
    logic prev_vs;
    last_fs = -1; vs_clks = 0; periods = 0; wrap_next = 0;
    prev_vs = s_vs;
    for (int i = 0; i < 3 * S_FRAME + 16 && failed < MAX_FAIL; i++) begin
      tick();
      if (wrap_next) begin
        tests_run++;
        if ((s_h !== 10'd0) || (s_v !== 10'd0) || (s_fs !== 1'b1)) begin
          failed++;
          $display("[TB] FAIL frame_wrap got h=%0d v=%0d fs=%b want 0 0 1", s_h, s_v, s_fs);
        end
      end
      wrap_next = (s_pclk === 1'b1) && (s_h == 10'(S_HTOT - 1)) && (s_v == 10'(S_VTOT - 1));
      if (s_vs !== prev_vs) begin
        tests_run++;
        if (s_h !== 10'd0) begin
          failed++;
          $display("[TB] FAIL vsync_align got h=%0d want 0", s_h);
        end
      end
      prev_vs = s_vs;
      if (s_vs === 1'b0) begin
        vs_clks++;
        tests_run++;
        if ((s_v < 10'(S_VVIS + S_VFP)) || (s_v >= 10'(S_VVIS + S_VFP + S_VSYNC))) begin
          failed++;
          $display("[TB] FAIL vsync_line got v=%0d want %0d..%0d", s_v, S_VVIS + S_VFP,
                   S_VVIS + S_VFP + S_VSYNC - 1);
        end
      end
      if (s_fs === 1'b1) begin
        if (last_fs >= 0) begin
          periods++;
          tests_run++;
          if (k - last_fs !== S_FRAME) begin
            failed++;
            $display("[TB] FAIL frame_period got %0d clks want %0d", k - last_fs, S_FRAME);
          end
          tests_run++;
          if (vs_clks !== S_DIV * S_HTOT * S_VSYNC) begin
            failed++;
            $display("[TB] FAIL vsync_width got %0d clks want %0d", vs_clks, S_DIV * S_HTOT * S_VSYNC);
          end
        end
        last_fs = k;
        vs_clks = 0;
      end
      tests_run++;
      if (obs_s() !== model(k, g_s)) begin
        failed++;
        $display("[TB] FAIL frame_small k=%0d got %p want %p", k, obs_s(), model(k, g_s));
      end
      tests_run++;
      if (obs_d() !== model(k, g_d)) begin
        failed++;
        $display("[TB] FAIL frame_def k=%0d got %p want %p", k, obs_d(), model(k, g_d));
      end
    end
    tests_run++;
    if (periods < 2) begin
      failed++;
      $display("[TB] FAIL frame_count got %0d periods want >= 2", periods);
    end
  endtask

  task automatic test_line_wrap();
    while (k < 32000 && failed < MAX_FAIL) begin
      tick();
      tests_run++;
      if (obs_d() !== model(k, g_d)) begin
        failed++;
        $display("[TB] FAIL line_run_def k=%0d got %p want %p", k, obs_d(), model(k, g_d));
      end
      tests_run++;
      if (obs_s() !== model(k, g_s)) begin
        failed++;
        $display("[TB] FAIL line_run_small k=%0d got %p want %p", k, obs_s(), model(k, g_s));
      end
    end
    tests_run++;
    if ((d_h !== 10'd799) || (d_v !== 10'd9) || (d_le !== 1'b1)) begin
      failed++;
      $display("[TB] FAIL line_wrap_pre got h=%0d v=%0d le=%b want 799 9 1", d_h, d_v, d_le);
    end
    tick();
    tests_run++;
    if ((d_h !== 10'd0) || (d_v !== 10'd10) || (d_le !== 1'b0)) begin
      failed++;
      $display("[TB] FAIL line_wrap_post got h=%0d v=%0d le=%b want 0 10 0", d_h, d_v, d_le);
    end
  endtask

  task automatic test_mid_frame_reset();
    int target, hold;
    target = 4 * (10 * 800 + 300) + 1 + int'($urandom_range(0, 3));
    hold   = $urandom_range(2, 6);
    while (k < target && failed < MAX_FAIL) begin
      tick();
      tests_run++;
      if (obs_d() !== model(k, g_d)) begin
        failed++;
        $display("[TB] FAIL pre_reset_def k=%0d got %p want %p", k, obs_d(), model(k, g_d));
      end
    end
    tests_run++;
    if ((d_h !== 10'd300) || (d_v !== 10'd10)) begin
      failed++;
      $display("[TB] FAIL pre_reset_pos got h=%0d v=%0d want 300 10", d_h, d_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs_d() !== rst_vals) begin
      failed++;
      $display("[TB] FAIL async_reset_def got %p want %p", obs_d(), rst_vals);
    end
    tests_run++;
    if (obs_s() !== rst_vals) begin
      failed++;
      $display("[TB] FAIL async_reset_small got %p want %p", obs_s(), rst_vals);
    end
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 3300 && failed < MAX_FAIL; i++) begin
      tick();
      tests_run++;
      if (obs_d() !== model(k, g_d)) begin
        failed++;
        $display("[TB] FAIL resume_def k=%0d got %p want %p", k, obs_d(), model(k, g_d));
      end
      tests_run++;
      if (obs_s() !== model(k, g_s)) begin
        failed++;
        $display("[TB] FAIL resume_small k=%0d got %p want %p", k, obs_s(), model(k, g_s));
      end
    end
  endtask

  initial begin
    g_d = '{div: 4, hvis: 640, hfp: 16, hsync: 96, hbp: 48,
            vvis: 480, vfp: 10, vsync: 2, vbp: 33};
    g_s = '{div: S_DIV, hvis: S_HVIS, hfp: S_HFP, hsync: S_HSYNC, hbp: S_HBP,
            vvis: S_VVIS, vfp: S_VFP, vsync: S_VSYNC, vbp: S_VBP};
    rst_vals = '{h: 10'd0, v: 10'd0, pclk: 1'b0, valid: 1'b1,
                 hs: 1'b1, vs: 1'b1, le: 1'b0, fs: 1'b0};

    test_reset();
    test_pclk_spacing();
    test_hsync_line();
    test_vsync_frame();
    test_line_wrap();
    test_mid_frame_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
